// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
// Subtract mode is compiled in by defining CSA_SUB_EN.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int csa_nchunk(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 0;
  endfunction

  function automatic bit csa_cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width > 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Operand/result valid-ready bundle for the chunked serial adder.
// The sub select only exists when CSA_SUB_EN is defined.
interface csa_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
`ifdef CSA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;

`ifdef CSA_SUB_EN
  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum
  );
  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum
  );
`else
  modport master (
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, sum
  );
  modport slave (
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, sum
  );
`endif

endinterface

// File: rtl/chunked_serial_adder_chunk_rca.sv
// Combinational CHUNK-bit ripple-carry adder: a chain of 1-bit full adders.
// Sets the per-cycle critical path of the serial adder.
module chunk_rca #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout
);

  always_comb begin
    logic w_c;
    o_s    = '0;
    w_c    = i_cin;
    for (int i = 0; i < CHUNK; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// WIDTH-bit adder computing CHUNK bits per clock with a registered inter-chunk carry.
// Define CSA_SUB_EN to add a subtract mode (x + ~y + 1, cin ignored).
module chunked_serial_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic  i_clk,
  input  logic  i_reset,
  csa_if.slave  s_if
);

  localparam int NCHUNK = csa_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (!csa_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH:0]   r_sum;

  logic [WIDTH-1:0] w_y_in;
  logic             w_c_in;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;

  // Subtraction is folded into the operands at acceptance so RUN only ever adds.
`ifdef CSA_SUB_EN
  assign w_y_in = s_if.sub ? ~s_if.y : s_if.y;
  assign w_c_in = s_if.sub ? 1'b1 : s_if.cin;
`else
  assign w_y_in = s_if.y;
  assign w_c_in = s_if.cin;
`endif

  assign w_a = r_x[r_idx*CHUNK +: CHUNK];
  assign w_b = r_y[r_idx*CHUNK +: CHUNK];

  chunk_rca #(
    .CHUNK (CHUNK)
  ) u_chunk_rca (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (s_if.in_valid) begin
            r_x        <= s_if.x;
            r_y        <= w_y_in;
            r_carry    <= w_c_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_sum[r_idx*CHUNK +: CHUNK] <= w_s;
          r_carry                     <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_sum[WIDTH] <= w_cout;
            r_idx        <= '0;
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          // sum is left untouched here so it stays readable after the handshake.
          if (s_if.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign s_if.in_ready  = r_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.sum       = r_sum;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed and random checks of chunked_serial_adder (WIDTH=32, CHUNK=8) with a result scoreboard.
// Subtract cases are included when CSA_SUB_EN is defined.
module tb_chunked_serial_adder;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int SW    = WIDTH + 1;
  localparam int NCH   = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;

  csa_if #(.WIDTH(WIDTH)) ifc ();

  chunked_serial_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .s_if    (ifc)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            n_pops   = 0;
  int            cyc      = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] last_sum = '0;
  logic [SW-1:0] hold_exp;
  int            acc;
  int            last_acc;

  function automatic logic [SW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + SW'(1);
    return {1'b0, a} + {1'b0, b} + SW'(c);
  endfunction

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict the handshakes of the coming edge from the settled signals, then advance.
  task automatic cycle();
    logic s_v;
    s_v = 1'b0;
`ifdef CSA_SUB_EN
    s_v = ifc.sub;
`endif
    if (!rst && ifc.in_valid === 1'b1 && ifc.in_ready === 1'b1)
      exp_q.push_back(model(ifc.x, ifc.y, ifc.cin, s_v));
    if (!rst && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_empty observed=%0d queued expected=at least 1", exp_q.size());
      end
      if (exp_q.size() > 0) begin
        last_sum = ifc.sum;
        chk("sb_sum", ifc.sum, exp_q.pop_front());
      end
      n_pops++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_pop(input string tag, input int maxc);
    int start;
    start = n_pops;
    for (int k = 0; k < maxc && n_pops == start; k++) cycle();
    n_assert++;
    assert (n_pops != start) else begin
      n_fail++;
      $error("FAIL %s_timeout observed=no result expected=result within %0d cycles", tag, maxc);
    end
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    for (int k = 0; k < maxc && ifc.out_valid !== 1'b1; k++) cycle();
    chk(tag, SW'(ifc.out_valid), SW'(1));
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    ifc.x        = a;
    ifc.y        = b;
    ifc.cin      = c;
    ifc.in_valid = 1'b1;
    cycle();
    ifc.in_valid = 1'b0;
  endtask

  task automatic rand_ops();
    ifc.x   = $urandom();
    ifc.y   = $urandom();
    ifc.cin = 1'($urandom_range(1, 0));
`ifdef CSA_SUB_EN
    ifc.sub = 1'($urandom_range(1, 0));
`endif
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.x         = '0;
    ifc.y         = '0;
    ifc.cin       = 1'b0;
    ifc.out_ready = 1'b0;
`ifdef CSA_SUB_EN
    ifc.sub       = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", SW'(ifc.in_ready), SW'(1));
    chk("rst_out_valid", SW'(ifc.out_valid), SW'(0));
    chk("rst_sum", ifc.sum, SW'(0));

    // Full carry propagation across every chunk; check exact latency.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (NCH - 1) cycle();
    chk("t1_lat_early", SW'(ifc.out_valid), SW'(0));
    cycle();
    chk("t1_lat_on_time", SW'(ifc.out_valid), SW'(1));
    chk("t1_in_ready_busy", SW'(ifc.in_ready), SW'(0));
    ifc.out_ready = 1'b1;
    cycle();
    ifc.out_ready = 1'b0;
    chk("t1_sum_const", last_sum, 33'h1_0000_0000);
    chk("t1_idle_ready", SW'(ifc.in_ready), SW'(1));
    chk("t1_idle_valid", SW'(ifc.out_valid), SW'(0));
    chk("t1_sum_held", ifc.sum, 33'h1_0000_0000);

    // Operands change right after acceptance; the latched copy must be used.
    ifc.out_ready = 1'b1;
    send(32'h1234_5678, 32'h1111_1111, 1'b1);
    ifc.x = 32'hFFFF_FFFF;
    ifc.y = 32'hFFFF_FFFF;
    wait_pop("t2", 20);
    chk("t2_sum_const", last_sum, 33'h0_2345_678A);

    // Backpressure in DONE while a second operand waits.
    ifc.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    wait_valid("bp_valid_wait", 20);
    hold_exp = exp_q[0];
    chk("bp_exp_const", hold_exp, 33'h0_DFD1_0456);
    ifc.x        = 32'h0F0F_0F0F;
    ifc.y        = 32'hF0F0_F0F0;
    ifc.cin      = 1'b1;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_sum_stable", ifc.sum, hold_exp);
      chk("bp_in_ready", SW'(ifc.in_ready), SW'(0));
      chk("bp_out_valid", SW'(ifc.out_valid), SW'(1));
      cycle();
    end
    chk("bp_not_accepted", SW'(exp_q.size()), SW'(1));
    ifc.out_ready = 1'b1;
    cycle();
    chk("bp_first_sum", last_sum, hold_exp);
    chk("bp_ready_after", SW'(ifc.in_ready), SW'(1));
    chk("bp_still_waiting", SW'(exp_q.size()), SW'(0));
    cycle();
    ifc.in_valid = 1'b0;
    wait_pop("bp_second", 20);
    chk("bp_second_const", last_sum, 33'h1_0000_0000);

    // Reset after two RUN cycles discards the operation.
    send(32'hAAAA_5555, 32'h5555_AAAA, 1'b0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_out_valid", SW'(ifc.out_valid), SW'(0));
    chk("mid_rst_in_ready", SW'(ifc.in_ready), SW'(1));
    chk("mid_rst_sum", ifc.sum, SW'(0));
    exp_q.delete();
    send(32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_pop("post_rst", 20);
    chk("post_rst_const", last_sum, SW'(2));

    // Back-to-back random traffic with in_valid and out_ready held high.
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    rand_ops();
    acc      = 0;
    last_acc = 0;
    for (int k = 0; k < 8000 && acc < 1000; k++) begin
      if (ifc.in_ready === 1'b1) begin
        if (acc > 0) chk("b2b_gap", SW'(cyc - last_acc), SW'(NCH + 2));
        last_acc = cyc;
        acc++;
      end
      cycle();
      rand_ops();
    end
    ifc.in_valid = 1'b0;
    chk("b2b_accepted", SW'(acc), SW'(1000));
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) cycle();
    chk("b2b_drain", SW'(exp_q.size()), SW'(0));

`ifdef CSA_SUB_EN
    ifc.sub = 1'b1;
    send(32'd5, 32'd7, 1'b0);
    wait_pop("sub_borrow", 20);
    chk("sub_borrow_const", last_sum, 33'h0_FFFF_FFFE);
    send(32'd7, 32'd5, 1'b1);
    wait_pop("sub_noborrow", 20);
    chk("sub_noborrow_const", last_sum, 33'h1_0000_0002);
    ifc.sub = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
